// File: rtl/sha256_pkg.sv
// sha256_pkg: shared state encoding and constants for the SHA-256 front end
package sha256_pkg;
  typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_e;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int BLOCK_WORDS = 16;
  localparam int LEN_W_DEF = 64;
endpackage

// File: rtl/sha256_pad_word.sv
// sha256_pad_word: keeps the valid bytes of a final word, inserts the 0x80 marker and zeroes the rest
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  input  logic        last_i,
  output logic [31:0] word_o
);
  // byte b survives when below nbytes; byte nbytes becomes the marker; later bytes clear
  always_comb begin
    word_o = data_i;
    for (int b = 0; b < 4; b++)
      if (last_i && 3'(b) >= nbytes_i) word_o[31-8*b -: 8] = (3'(b) == nbytes_i) ? PAD_BYTE : 8'h00;
  end
endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: packs a 32-bit word stream into padded 512-bit SHA-256 blocks
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic [511:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_last
);
  state_e             state_q, state_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [LEN_W-1:0]   bitlen_q, bitlen_d, len_new;
  logic               pending_q, pending_d;
  logic               pad_done_q, pad_done_d;
  logic               last_q, last_d;
  logic [31:0]        blk_q [BLOCK_WORDS];
  logic [31:0]        blk_d [BLOCK_WORDS];
  logic [31:0]        pad_w;
  logic [63:0]        len_acc, len_cur;
  logic [4:0]         pad_slot;
  logic               accept;

  sha256_pad_word u_pad (
    .data_i   (in_data),
    .nbytes_i (in_nbytes),
    .last_i   (in_last),
    .word_o   (pad_w)
  );

  assign in_ready    = (state_q == FILL) && !rst;
  assign block_valid = state_q == EMIT;
  assign block_last  = last_q;
  assign accept      = in_valid && in_ready;
  assign len_new     = bitlen_q + LEN_W'({in_nbytes, 3'b000});
  assign len_acc     = 64'(len_new);
  assign len_cur     = 64'(bitlen_q);
  // a full final word pushes the marker into the following slot
  assign pad_slot    = {1'b0, wcnt_q} + {4'b0, in_nbytes == 3'd4};

  // word 0 sits in the most significant bits of the block
  always_comb begin
    for (int k = 0; k < BLOCK_WORDS; k++) block_out[511-32*k -: 32] = blk_q[k];
  end

  // next-state: word collection, padding decisions and block handshakes
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    bitlen_d   = bitlen_q;
    pending_d  = pending_q;
    pad_done_d = pad_done_q;
    last_d     = last_q;
    blk_d      = blk_q;
    case (state_q)
      FILL: if (accept) begin
        bitlen_d       = len_new;
        wcnt_d         = wcnt_q + 4'd1;
        blk_d[wcnt_q]  = pad_w;
        if (!in_last) begin
          if (wcnt_q == 4'd15) begin
            state_d = EMIT;
            last_d  = 1'b0;
          end
        end else begin
          for (int k = 0; k < BLOCK_WORDS; k++) if (k > int'(wcnt_q)) blk_d[k] = 32'h0;
          if (in_nbytes == 3'd4 && wcnt_q != 4'd15) blk_d[wcnt_q + 4'd1] = {PAD_BYTE, 24'h0};
          state_d = EMIT;
          if (pad_slot <= 5'd13) begin
            blk_d[14] = len_acc[63:32];
            blk_d[15] = len_acc[31:0];
            last_d    = 1'b1;
          end else begin
            pending_d  = 1'b1;
            pad_done_d = pad_slot <= 5'd15;
            last_d     = 1'b0;
          end
        end
      end
      EMIT: if (block_ready) begin
        state_d = pending_q ? EXTRA : FILL;
        wcnt_d  = 4'd0;
        last_d  = 1'b0;
        if (last_q) begin
          bitlen_d   = '0;
          pending_d  = 1'b0;
          pad_done_d = 1'b0;
        end
      end
      EXTRA: begin
        blk_d      = '{default: 32'h0};
        blk_d[0]   = pad_done_q ? 32'h0 : {PAD_BYTE, 24'h0};
        blk_d[14]  = len_cur[63:32];
        blk_d[15]  = len_cur[31:0];
        last_d     = 1'b1;
        pending_d  = 1'b0;
        pad_done_d = 1'b0;
        state_d    = EMIT;
      end
      default: state_d = FILL;
    endcase
  end

  // state registers, cleared asynchronously so a reset discards any partial message
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      wcnt_q     <= 4'd0;
      bitlen_q   <= '0;
      pending_q  <= 1'b0;
      pad_done_q <= 1'b0;
      last_q     <= 1'b0;
      blk_q      <= '{default: 32'h0};
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      bitlen_q   <= bitlen_d;
      pending_q  <= pending_d;
      pad_done_q <= pad_done_d;
      last_q     <= last_d;
      blk_q      <= blk_d;
    end
  end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: table-driven message stimulus checked against a byte-level padding model
module tb_sha256_msg_padder;
  logic         clk = 0;
  logic         rst = 0;
  logic [31:0]  in_data = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic         in_last = 0;
  logic [2:0]   in_nbytes = 0;
  logic [511:0] block_out;
  logic         block_valid;
  logic         block_ready = 1;
  logic         block_last;

  int errors = 0;
  int checks = 0;
  int rx_blocks = 0;
  logic [511:0] last_blk = 0;

  typedef struct { logic [511:0] blk; logic last; } exp_t;
  exp_t q[$];

  typedef struct { int len; bit abc; int nblk; } vec_t;
  vec_t tv[12];

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 448'h0, 32'h00000000};

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_nbytes   (in_nbytes),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_last  (block_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && block_valid && block_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_block got=%h", block_out);
      end else begin
        e = q.pop_front();
        if (block_out !== e.blk || block_last !== e.last) begin
          errors++;
          $display("FAIL block got=%h last=%b exp=%h last=%b", block_out, block_last, e.blk, e.last);
        end
      end
      rx_blocks++;
      last_blk = block_out;
    end
  end

  task automatic send_msg(input int len, input bit abc, input int seed);
    byte unsigned m[$];
    byte unsigned p[$];
    logic [63:0] bl;
    logic [511:0] blk;
    int nb, nw, t;
    for (int i = 0; i < len; i++) m.push_back(abc ? 8'(8'h61 + i) : 8'((seed + i * 37) & 255));
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(len) * 64'd8;
    for (int j = 7; j >= 0; j--) p.push_back(8'(bl >> (8 * j)));
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      q.push_back('{blk, b == nb - 1});
    end
    nw = (len == 0) ? 1 : (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 4; j++) in_data[31-8*j -: 8] = (4*w + j < len) ? m[4*w+j] : 8'hA5;
      in_last   = (w == nw - 1);
      in_nbytes = in_last ? 3'(len - 4*w) : 3'd4;
      in_valid  = 1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
        t++;
        @(negedge clk);
      end
      if (t >= 200) begin
        errors++;
        $display("FAIL accept_timeout got=in_ready_low exp=in_ready_high");
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("drain_pending", 512'(q.size()), 512'd0);
  endtask

  initial begin
    int rx0, t;
    logic [511:0] hold;
    tv[0]  = '{3,   1'b1, 1};
    tv[1]  = '{0,   1'b0, 1};
    tv[2]  = '{55,  1'b0, 1};
    tv[3]  = '{56,  1'b0, 2};
    tv[4]  = '{63,  1'b0, 2};
    tv[5]  = '{64,  1'b0, 2};
    tv[6]  = '{65,  1'b0, 2};
    tv[7]  = '{119, 1'b0, 2};
    tv[8]  = '{120, 1'b0, 3};
    tv[9]  = '{4,   1'b0, 1};
    tv[10] = '{60,  1'b0, 2};
    tv[11] = '{128, 1'b0, 3};

    #1 rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_block_valid", 512'(block_valid), 512'd0);
    chk("rst_block_last", 512'(block_last), 512'd0);
    chk("rst_in_ready", 512'(in_ready), 512'd0);
    chk("rst_block_out", block_out, 512'd0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", 512'(in_ready), 512'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      rx0 = rx_blocks;
      send_msg(tv[i].len, tv[i].abc, i * 11 + 3);
      wait_drain();
      chk($sformatf("blocks_len%0d", tv[i].len), 512'(rx_blocks - rx0), 512'(tv[i].nblk));
      if (tv[i].abc) chk("abc_block", last_blk, ABC_BLK);
      if (tv[i].len == 0) chk("empty_block", last_blk, EMPTY_BLK);
    end

    block_ready = 0;
    send_msg(10, 1'b0, 5);
    t = 0;
    @(negedge clk);
    while (!block_valid && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("stall_valid_rise", 512'(block_valid), 512'd1);
    hold = block_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 512'(block_valid), 512'd1);
      chk("stall_hold", block_out, hold);
      chk("stall_in_ready", 512'(in_ready), 512'd0);
    end
    block_ready = 1;
    wait_drain();

    for (int i = 0; i < 7; i++) begin
      in_data   = 32'h1000_0000 + 32'(i);
      in_nbytes = 3'd4;
      in_last   = 0;
      in_valid  = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_block_valid", 512'(block_valid), 512'd0);
    chk("midrst_block_last", 512'(block_last), 512'd0);
    chk("midrst_in_ready", 512'(in_ready), 512'd0);
    chk("midrst_block_out", block_out, 512'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("midrst_release_ready", 512'(in_ready), 512'd1);
    @(posedge clk);
    #1;
    send_msg(3, 1'b1, 0);
    wait_drain();
    chk("abc_after_rst", last_blk, ABC_BLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sha256_msg_padder.md
SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 SHALL have parameter LEN_W, default 64, width of the message bit-length counter (fixed at 64 for standard SHA-256).
REQ-002 SHALL have port clk  input  1  single clock for all logic, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_data  input  32  message word, big-endian (byte 0 in bits 31:24).
REQ-005 SHALL have port in_valid  input  1  in_data/in_last/in_nbytes valid.
REQ-006 SHALL have port in_ready  output  1  padder accepts a word this cycle.
REQ-007 SHALL have port in_last  input  1  final word of message.
REQ-008 SHALL have port in_nbytes  input  3  valid bytes in word: 4 when in_last=0; 0..4 when in_last=1.
REQ-009 SHALL have port block_out  output  512  padded block, word 0 in bits 511:480; feeds core message_block.
REQ-010 SHALL have port block_valid  output  1  block_out holds a complete block.
REQ-011 SHALL have port block_ready  input  1  downstream core accepts the block (core idle or done).
REQ-012 SHALL have port block_last  output  1  qualifies block_valid: final block of the message.

Function
REQ-013 SHALL accept a word only on in_valid && in_ready; it SHALL transfer a block only on block_valid && block_ready.
REQ-014 SHALL implement states FILL, EMIT, EXTRA; reset state FILL.
REQ-015 In FILL, SHALL assert in_ready; each accepted word is written to word slot wcnt (0..15), wcnt increments, and bitlen increments by 8*in_nbytes.
REQ-016 On acceptance with in_last=0 and wcnt=15, SHALL go to EMIT with block_last=0.
REQ-017 On acceptance with in_last=1, SHALL place 0x80 in byte position in_nbytes of the current word (or in byte 0 of the next word if in_nbytes=4), zero all remaining bytes of the current and subsequent slots.
REQ-018 If the 0x80 byte lands in slot <=13, SHALL write the final 64-bit bitlen big-endian into slots 14-15, set block_last=1, go to EMIT.
REQ-019 Otherwise (0x80 in slot 14 or 15, or 0x80 overflowing slot 15), SHALL go to EMIT with block_last=0 and mark an extra block pending.
REQ-020 In EMIT, SHALL hold block_valid=1 and block_out stable, in_ready=0; on block_ready, SHALL go to EXTRA if an extra block is pending, else to FILL with wcnt=0.
REQ-021 In EXTRA, SHALL build a block of zeros with 0x80 at byte 0 only if 0x80 was not yet emitted, bitlen in slots 14-15, block_last=1, then go to EMIT.
REQ-022 After a block_last transfer, SHALL clear bitlen, wcnt and pending flags before the next message.
REQ-023 SHALL support the empty message (in_last=1, in_nbytes=0, wcnt=0): block = 0x80000000, zeros, length 0.
REQ-024 SHALL ignore in_data bytes beyond in_nbytes.
REQ-025 bitlen SHALL wrap modulo 2^LEN_W without error.
REQ-026 Latency: block_valid SHALL rise one cycle after the accepting edge of the slot-15 word or in_last word.

Reset
REQ-027 While rst=1, SHALL force state FILL, wcnt=0, bitlen=0, pending=0, block_out=0, block_valid=0, block_last=0, in_ready=0.
REQ-028 Reset asserted mid-message or during EMIT SHALL discard the partial message; the first cycle after release SHALL assert in_ready=1.

Structure
REQ-029 SHALL place state encoding, PAD_BYTE (0x80), BLOCK_WORDS (16) and LEN_W default in shared package sha256_pkg.
REQ-030 SHALL use one sub-module, sha256_pad_word, combinational: inserts 0x80 and masks bytes for a given in_nbytes.
REQ-031 SHALL be instantiable directly upstream of sha256_top, block_out to message_block, block_valid&&block_ready to start.

Verification
REQ-032 "abc" (0x61626300, in_nbytes=3, in_last) -> one block: word0 0x61626380, words1-14 0, word15 0x00000018, block_last=1.
REQ-033 Empty message -> one block 0x80000000, rest 0, block_last=1.
REQ-034 55 bytes -> one block, length 0x1B8; 56 bytes -> two blocks, second all zero except word15 0x000001C0, first block_last=0.
REQ-035 64 bytes -> two blocks; second word0 0x80000000, word15 0x00000200, block_last=1.
REQ-036 Hold block_ready=0 for 10 cycles in EMIT -> block_valid, block_out stable, in_ready=0 throughout.
REQ-037 Assert rst after 7 words of a message -> all outputs zero; next message "abc" yields REQ-032 block exactly.
